// File: rtl/spi_peripheral.sv
// SPI mode-0 target: 16-bit frames write or read back the nine 8-bit PWM control registers.
// SPI pins are synchronized into clk; the addressed register changes only at the ncs-rise commit.
//
// state | meaning
// IDLE  | ncs high (or not yet armed after reset); sclk edges ignored
// SHIFT | frame in progress: sample copi on sclk rise, drive cipo on reads

module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic       cipo_oe,
    output logic [7:0] reg_en_out,
    output logic [7:0] reg_en_pwm_out,
    output logic [7:0] reg_out_3_0_pwm_gen_channel,
    output logic [7:0] reg_out_7_4_pwm_gen_channel,
    output logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_0_frequency_divider,
    output logic       frame_err
);

    localparam int SW = $clog2(SYNC_STAGES + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sclk_prev;
    logic                   ncs_prev;
    logic [4:0]             bit_cnt;
    logic [15:0]            shift_in;
    logic [7:0]             rd_shift;
    logic [7:0]             rd_val;
    logic [6:0]             rd_addr;
    logic [SW-1:0]          settle_cnt;
    logic                   armed;
    logic [7:0]             regs [NUM_REGS];

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;

    // Address is complete on the 8th rising edge: six bits already shifted plus the live copi bit.
    assign rd_addr = {shift_in[5:0], copi_s};

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) rd_val = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            rd_shift   <= '0;
            cipo       <= 1'b0;
            cipo_oe    <= 1'b0;
            frame_err  <= 1'b0;
            settle_cnt <= SW'(SYNC_STAGES + 1);
            armed      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            frame_err <= 1'b0;
            // A fall seen while the chain still holds its reset value of 1 is not a real frame start.
            if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
            else if (ncs_s)       armed      <= 1'b1;

            case (state)
                IDLE: begin
                    cipo     <= 1'b0;
                    rd_shift <= '0;
                    cipo_oe  <= 1'b0;
                    if (ncs_fall && armed) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        shift_in <= '0;
                        cipo_oe  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state    <= IDLE;
                        cipo_oe  <= 1'b0;
                        cipo     <= 1'b0;
                        rd_shift <= '0;
                        if (bit_cnt == 5'd16) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (shift_in[15] && shift_in[14:8] == 7'(i)) regs[i] <= shift_in[7:0];
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift_in <= {shift_in[14:0], copi_s};
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7 && !shift_in[6]) begin
                            rd_shift <= rd_val;
                            cipo     <= rd_val[7];
                        end
                    end else if (sclk_fall && bit_cnt >= 5'd9) begin
                        // bit7 is held until the controller samples it on the 9th rising edge
                        rd_shift <= {rd_shift[6:0], 1'b0};
                        cipo     <= rd_shift[6];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fixed output map assumes NUM_REGS >= 9.
    assign reg_en_out                        = regs[0];
    assign reg_en_pwm_out                    = regs[1];
    assign reg_out_3_0_pwm_gen_channel       = regs[2];
    assign reg_out_7_4_pwm_gen_channel       = regs[3];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = regs[4];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = regs[5];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = regs[6];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = regs[7];
    assign reg_pwm_gen_1_0_frequency_divider = regs[8];

endmodule
